// File: rtl/hazard_pkg.sv
// Shared types, opcode constants and operand-usage helpers for the pipeline
// hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Non-frozen DRAIN cycles needed for EX, MEM and WB to retire.
  localparam logic [1:0] DRAIN_LAST = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 8'b11111_000;
  localparam ctrl_t CTRL_FREEZE = 8'b00000_000;
  localparam ctrl_t CTRL_FLUSH  = 8'b11111_111;
  localparam ctrl_t CTRL_HOLD   = 8'b00111_010;

  // ALU ops, LW base, SW base and BR base all read rs.
  function automatic logic uses_rs(input logic [3:0] op);
    return (op < OP_LW) || (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return (op <= 4'h3) || (op == 4'h7);
  endfunction

  // SW reads its store data through rd; 0xA and 0xB do the same.
  function automatic logic uses_rd_src(input logic [3:0] op);
    return (op == OP_SW) || (op == 4'hA) || (op == 4'hB);
  endfunction

endpackage

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a
// source operand of the instruction waiting in IF/ID.
module hazard_load_use_detect
  import hazard_pkg::*;
(
  input  logic [15:0] ifid_instr,
  input  logic        idex_mem_read,
  input  logic [3:0]  idex_rd,
  output logic        load_use
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [3:0] rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       rd_hit;

  assign {op, rd, rs, rt} = ifid_instr;

  assign rs_hit = uses_rs(op)     && (rs == idex_rd);
  assign rt_hit = uses_rt(op)     && (rt == idex_rd);
  assign rd_hit = uses_rd_src(op) && (rd == idex_rd);

  // r0 is hard-wired, so a load into it never creates a dependency.
  assign load_use = idex_mem_read && (idex_rd != 4'd0) && (rs_hit || rt_hit || rd_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch
// flushes, memory freeze with timeout, HLT drain. HAZARD_PERF_CNT_EN adds counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ifid_instr,
  input  logic        idex_mem_read,
  input  logic [3:0]  idex_rd,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        halted,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [15:0] TIMEOUT_LIM = MEM_TIMEOUT[15:0];

  hz_state_e   state;
  hz_state_e   state_nxt;
  logic [1:0]  drain_cnt;
  logic [1:0]  drain_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic [15:0] wait_inc;
  logic        timeout_nxt;
  logic        load_use;
  logic        is_hlt;
  ctrl_t       ctrl;

  hazard_load_use_detect u_load_use (
    .ifid_instr    (ifid_instr),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .load_use      (load_use)
  );

  assign is_hlt   = (ifid_instr[15:12] == OP_HLT);
  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    ctrl        = CTRL_FREEZE;
    halted      = 1'b0;
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    wait_nxt    = wait_cnt;
    timeout_nxt = mem_timeout;

    if (!rst) begin
      case (state)
        HALTED: begin
          halted   = 1'b1;
          wait_nxt = 16'd0;
        end
        default: begin
          if (mem_busy) begin
            ctrl     = CTRL_FREEZE;
            wait_nxt = wait_inc;
            if (wait_inc >= TIMEOUT_LIM) timeout_nxt = 1'b1;
          end else begin
            wait_nxt = 16'd0;
            if (branch_taken) begin
              // A taken branch also cancels a speculative HLT still draining.
              ctrl      = CTRL_FLUSH;
              state_nxt = RUN;
            end else if (state == DRAIN) begin
              ctrl      = CTRL_HOLD;
              drain_nxt = drain_cnt + 2'd1;
              if (drain_nxt == DRAIN_LAST) state_nxt = HALTED;
            end else if (load_use) begin
              ctrl = CTRL_HOLD;
            end else if (is_hlt) begin
              ctrl      = CTRL_HOLD;
              drain_nxt = 2'd0;
              state_nxt = DRAIN;
            end else begin
              ctrl = CTRL_RUN;
            end
          end
        end
      endcase
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_bubble = ctrl.exmem_bubble;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      drain_cnt   <= 2'd0;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !rst && (state != HALTED) && !ctrl.pc_en;
  assign flush_inc = !rst && (state != HALTED) && !mem_busy && branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_inc && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush_inc && (flush_count  != 16'hFFFF)) flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ifid_instr;
  logic        idex_mem_read;
  logic [3:0]  idex_rd;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, exmem_bubble;
  logic        halted, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  pipeline_hazard_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifid_instr    (ifid_instr),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .exmem_bubble  (exmem_bubble),
    .halted        (halted),
    .mem_timeout   (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: halt_phase 0 = running, 1..3 = draining, 4 = halted.
  int halt_phase = 0;
  int busy_run   = 0;
  bit m_timeout  = 1'b0;
  int m_stall    = 0;
  int m_flush    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source-usage tables indexed by opcode.
  function automatic bit model_load_use(input logic [15:0] ins, input bit mr, input logic [3:0] xrd);
    logic [15:0] rs_users;
    logic [15:0] rt_users;
    logic [15:0] rd_users;
    logic [3:0]  op;
    rs_users = 16'h23FF;
    rt_users = 16'h008F;
    rd_users = 16'h0E00;
    op = ins[15:12];
    if (!mr || xrd == 4'd0) return 1'b0;
    return (rs_users[op] && ins[7:4] == xrd) ||
           (rt_users[op] && ins[3:0] == xrd) ||
           (rd_users[op] && ins[11:8] == xrd);
  endfunction

  task automatic step(input bit r, input logic [15:0] ins, input bit mr,
                      input logic [3:0] xrd, input bit br, input bit busy);
    logic [4:0] en;
    logic [2:0] fb;
    bit         h;
    bit         lu;
    rst           = r;
    ifid_instr    = ins;
    idex_mem_read = mr;
    idex_rd       = xrd;
    branch_taken  = br;
    mem_busy      = busy;
    @(negedge clk);
    lu = model_load_use(ins, mr, xrd);
    h  = 1'b0;
    if (r) begin
      en = 5'b00000; fb = 3'b000;
    end else if (halt_phase == 4) begin
      en = 5'b00000; fb = 3'b000; h = 1'b1;
    end else if (busy) begin
      en = 5'b00000; fb = 3'b000;
    end else if (br) begin
      en = 5'b11111; fb = 3'b111;
    end else if (halt_phase > 0 || lu || ins[15:12] == 4'hF) begin
      en = 5'b00111; fb = 3'b010;
    end else begin
      en = 5'b11111; fb = 3'b000;
    end
    check("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, en);
    check("flush_bubble", {ifid_flush, idex_bubble, exmem_bubble}, fb);
    check("halted", halted, h);
    check("mem_timeout", mem_timeout, m_timeout);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count", flush_count, m_flush);
`endif
    @(posedge clk);
    if (r) begin
      halt_phase = 0; busy_run = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    end else if (halt_phase == 4) begin
      busy_run = 0;
    end else if (busy) begin
      if (busy_run < 65535) busy_run++;
      if (busy_run >= TIMEOUT) m_timeout = 1'b1;
      if (m_stall < 65535) m_stall++;
    end else begin
      busy_run = 0;
      if (br) begin
        halt_phase = 0;
        if (m_flush < 65535) m_flush++;
      end else begin
        if (!en[4] && m_stall < 65535) m_stall++;
        if (halt_phase > 0) halt_phase++;
        else if (!lu && ins[15:12] == 4'hF) halt_phase = 1;
      end
    end
    #1;
  endtask

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] HLT = 16'hF000;

  initial begin
    bit         r, mr, br, busy, prev_busy;
    logic [15:0] ins;
    logic [3:0]  xrd;

    rst = 1'b1; ifid_instr = NOP; idex_mem_read = 1'b0; idex_rd = 4'd0;
    branch_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk); #1;
    step(1, NOP, 0, 0, 0, 0);

    // Load-use: ADD r3,r1,r2 behind LW r1, then the bubble clears MemRead.
    step(0, 16'h0312, 1, 4'd1, 0, 0);
    step(0, 16'h0312, 0, 4'd0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("plan_stall_after_load_use", stall_cycles, 16'd1);
`endif
    // Load into r0 never stalls.
    step(0, 16'h0302, 1, 4'd0, 0, 0);
    // Branch wins over a simultaneous load-use.
    step(0, 16'h0312, 1, 4'd1, 1, 0);

    // Five busy cycles with a timeout of three.
    for (int i = 0; i < 5; i++) step(0, 16'h0312, 1, 4'd1, 0, 1);
    step(0, NOP, 0, 0, 0, 0);
    check("plan_timeout_sticky", mem_timeout, 1'b1);

    // HLT drains to halted in four cycles; halted ignores busy/branch.
    step(1, NOP, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, HLT, 0, 0, 0, 0);
    check("plan_halted", halted, 1'b1);
    step(0, HLT, 0, 0, 1, 1);

    // Branch in DRAIN cycle 2 cancels the halt.
    step(1, NOP, 0, 0, 0, 0);
    step(0, HLT, 0, 0, 0, 0);
    step(0, HLT, 0, 0, 0, 0);
    step(0, HLT, 0, 0, 1, 0);
    step(0, NOP, 0, 0, 0, 0);
    check("plan_branch_cancels_halt", halted, 1'b0);

    // Reset while draining returns to RUN.
    step(0, HLT, 0, 0, 0, 0);
    step(0, HLT, 0, 0, 0, 0);
    step(1, HLT, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 0);

    // Randomized traffic with bursty mem_busy and occasional resets.
    prev_busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 99) < 2) || (halt_phase == 4 && $urandom_range(0, 3) == 0);
      ins  = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      mr   = $urandom_range(0, 1) == 1;
      xrd  = 4'($urandom_range(0, 3));
      br   = $urandom_range(0, 9) == 0;
      busy = prev_busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
      prev_busy = busy;
      step(r, ins, mr, xrd, br, busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush controller for the 5-stage 16-bit pipeline. It drives the write-enable and bubble inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB; the ID/EX register is one of its main consumers. It detects load-use hazards against the instruction held in IF/ID and flushes wrong-path instructions on a taken branch. It freezes the whole pipe while data memory is busy and drains the pipe on HLT.

## Interface
Parameters:
- MEM_TIMEOUT, 255: consecutive mem_busy cycles before mem_timeout is set. Range 1–65535.

Ports:
- Clock and reset are fixed: `clk` is the single clock, and `rst` is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- ifid_instr  in  16  instruction in IF/ID: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
- idex_mem_read  in  1  ID/EX MemRead (load in EX)
- idex_rd  in  4  destination register of the instruction in EX
- branch_taken  in  1  branch in MEM resolved taken this cycle
- mem_busy  in  1  data memory not ready; pipeline must hold
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage write enables
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads zeroed control signals
- exmem_bubble  out  1  EX/MEM loads zeroed control signals
- halted  out  1  pipe drained after HLT
- mem_timeout  out  1  sticky memory timeout error
- stall_cycles, flush_count  out  16 each  present only when the macro is defined

## Operation
- FSM states: RUN, DRAIN, HALTED. Outputs are combinational from the state and the inputs. State and counters are registered.
- Default in RUN: all enables 1; flush and bubble outputs 0.
- Priority within a cycle: rst > mem_busy > branch_taken > load-use > HLT.
- mem_busy (RUN or DRAIN):
  - All enables 0; flush and bubble outputs 0.
  - State and drain counter hold.
  - wait_cnt increments, saturating. When wait_cnt reaches MEM_TIMEOUT with mem_busy still high, mem_timeout is set. The freeze continues.
  - wait_cnt clears on the first cycle with mem_busy low.
- branch_taken (RUN or DRAIN):
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_en=1 (PC loads the target).
  - The next state is RUN. In DRAIN this cancels a speculative HLT.
- Load-use hazard: idex_mem_read & idex_rd!=0 & a match of idex_rd against any source field used by the IF/ID opcode.
  - rs [7:4] is a source for opcodes 0x0–0x9 and 0xD.
  - rt [3:0] is a source for opcodes 0x0–0x3 and 0x7.
  - rd [11:8] is a source for 0x9, 0xA and 0xB.
  - Response: pc_en=0, ifid_en=0, idex_bubble=1; other enables 1. This lasts exactly one cycle, because the bubble clears idex_mem_read.
- HLT (opcode 0xF) in IF/ID while in RUN with no higher-priority event:
  - pc_en=0, ifid_en=0, idex_bubble=1.
  - drain_cnt clears to 0 and the FSM enters DRAIN.
- DRAIN:
  - Outputs are the same as the HLT cycle.
  - drain_cnt increments on each non-frozen cycle.
  - When drain_cnt reaches 3 the FSM enters HALTED; the older EX, MEM and WB instructions have retired.
- HALTED:
  - All enables 0; halted=1.
  - mem_busy and branch_taken are ignored.
  - The only exit is rst.
- While rst is high: all enables 0; flush and bubble outputs 0; halted 0. On the next edge: state RUN, counters 0, mem_timeout 0.

## Timing
- Hazard response is combinational in the same cycle the condition is present. It takes effect at the next clk edge.
- Load-use penalty is 1 cycle. Taken-branch penalty is 3 flushed slots.
- HLT to halted takes 4 cycles, plus any mem_busy cycles.
- mem_timeout asserts on the cycle after the MEM_TIMEOUT-th consecutive busy cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds stall_cycles and flush_count, both 16-bit saturating and reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 in RUN or DRAIN.
  - flush_count increments on each taken-branch flush.
- HAZARD_PERF_CNT_EN undefined: both ports and the counter logic are absent.

## Structure
- hazard_pkg holds:
  - the state enum;
  - opcode constants: OP_LW=4'h8, OP_SW=4'h9, OP_BR=4'hD, OP_HLT=4'hF;
  - functions uses_rs, uses_rt, uses_rd_src.
- Sub-module hazard_load_use_detect (combinational): inputs ifid_instr, idex_mem_read and idex_rd; output load_use.

## Test plan
- ADD r3,r1,r2 with EX holding LW r1: pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle, then all enables 1.
- LW r0 in EX with ADD r3,r0,r2 in IF/ID: no stall, all enables 1.
- branch_taken coincident with a load-use hazard: ifid_flush=idex_bubble=exmem_bubble=1, pc_en=1, no stall.
- mem_busy held 5 cycles with MEM_TIMEOUT=3: all enables 0 for 5 cycles; mem_timeout rises after the 3rd busy cycle and stays set after mem_busy drops.
- HLT in IF/ID: halted=1 four cycles later.
- Same as above with branch_taken in DRAIN cycle 2: returns to RUN with halted=0.
- rst asserted in DRAIN: next cycle RUN, halted=0, all enables 1.
- With HAZARD_PERF_CNT_EN, after the first scenario: stall_cycles=1.
